sw_debounce_led: RTL
====================

// Module: sw_debounce_led
// PURPOSE
//  Switch-input companion to the board LED driver: samples one raw mechanical switch,
//  synchronises and debounces it, and issues one-cycle press/release pulses.
//  Each debounced press toggles LED0, so the block owns the input-to-LED path on the
//  board-bring-up exercise top level. All logic runs in the single CLK domain.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles needed to accept a level change (>=2)
//  LONG_CYCLES      50000000 cycles held after accepted press before LONG_PRESS fires (>=2)
// PORTS
//  CLK         in   1  system clock; the only clock
//  RST_N       in   1  reset, asynchronous assert, active-low
//  SW0         in   1  raw switch, asynchronous to CLK, 1 = pressed
//  LED0        out  1  LED state; toggles on every accepted press
//  PRESS       out  1  one-cycle pulse on accepted press
//  RELEASE     out  1  one-cycle pulse on accepted release
//  SW_STABLE   out  1  debounced switch level
//  LONG_PRESS  out  1  one-cycle pulse on long hold (see CONFIGURATION)
// BEHAVIOUR
//  Clock/reset: one clock CLK; reset RST_N is asynchronous and active-low.
//  - RST_N=0 forces all outputs, both synchroniser flops, counters and FSM to 0 / REL.
//    Release of RST_N is synchronised externally; no pulse is emitted on reset exit.
//  - Sync: two-flop synchroniser s1->s2; FSM sees s2 only. SW0 never feeds logic directly.
//  - Counter cnt, width $clog2(DEBOUNCE_CYCLES+1), unsigned; cleared on every FSM transition.
//  - FSM states: REL, PRESS_CHK, HELD, REL_CHK.
//    REL:       s2=1 -> PRESS_CHK, cnt=1; else stay.
//    PRESS_CHK: s2=0 -> REL (bounce rejected, no pulse);
//               s2=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD; else cnt++.
//    HELD:      s2=0 -> REL_CHK, cnt=1; else stay.
//    REL_CHK:   s2=1 -> HELD (bounce rejected);
//               s2=0 and cnt==DEBOUNCE_CYCLES-1 -> REL; else cnt++.
//  - PRESS is registered high for exactly the cycle after PRESS_CHK->HELD transition;
//    in that same edge LED0 <= ~LED0 and SW_STABLE <= 1.
//    RELEASE/SW_STABLE<=0 likewise on REL_CHK->REL. PRESS and RELEASE are never both 1.
//  - Latency: SW0 steady high from edge k -> s2=1 at edge k+2 -> PRESS high after
//    edge k+2+DEBOUNCE_CYCLES, for one cycle. Release symmetric.
//  - Any glitch shorter than DEBOUNCE_CYCLES cycles (post-sync) produces no output change.
//  - Counter never wraps: compare-to-terminal forces a transition before overflow.
//  - Reset mid-debounce: state lost, LED0=0; a still-held switch after reset
//    must be re-qualified from REL (produces a fresh PRESS and LED0=1).
// CONFIGURATION
//  Macro SW_LONG_PRESS_EN:
//   defined:   in HELD a second counter lcnt (width $clog2(LONG_CYCLES+1)) counts while
//              s2=1; on reaching LONG_CYCLES-1, LONG_PRESS pulses one cycle and LED0 <= 0.
//              Fires at most once per hold; lcnt saturates, clears on leaving HELD.
//              A bounce into REL_CHK that returns to HELD does NOT clear lcnt.
//   undefined: lcnt not built; LONG_PRESS tied 0; port list unchanged.
// TESTING  (DEBOUNCE_CYCLES=4, LONG_CYCLES=16, CLK period 10ns)
//  1 RST_N=0 with SW0=1, release reset at t0 -> all outputs 0; PRESS one cycle at edge 6, LED0=1.
//  2 From idle SW0 pulses high 3 cycles then low -> PRESS, LED0, SW_STABLE stay 0.
//  3 SW0 high 20 cycles, low 20, high 20 -> LED0 0->1->0, two PRESS pulses, one RELEASE between.
//  4 In HELD, SW0 low 2 cycles then high -> no RELEASE, SW_STABLE stays 1.
//  5 SW_LONG_PRESS_EN, SW0 held 40 cycles -> PRESS at edge 6, LONG_PRESS once 16 cycles later,
//    LED0 1->0; undefined build -> LONG_PRESS stays 0, LED0 stays 1.
//  6 RST_N pulsed low during PRESS_CHK (cnt=2) -> no PRESS; re-qualifies from REL after reset.

Source files
------------

// File: rtl/sw_debounce_led_if.sv
// Switch/LED signal bundle for sw_debounce_led; the DUT binds to the slave
// modport and the board/bench side drives the raw switch through master.
interface sw_debounce_led_if;
  logic SW0;
  logic LED0;
  logic PRESS;
  logic RELEASE;
  logic SW_STABLE;
  logic LONG_PRESS;

  modport master (output SW0, input LED0, PRESS, RELEASE, SW_STABLE, LONG_PRESS);
  modport slave  (input SW0, output LED0, PRESS, RELEASE, SW_STABLE, LONG_PRESS);
endinterface

// File: rtl/sw_debounce_led.sv
// Switch debouncer: 2-flop sync, press/release pulses DEBOUNCE_CYCLES after s2 settles, LED0 toggle
// per press, no backpressure; optional long-hold pulse under macro SW_LONG_PRESS_EN.
module sw_debounce_led #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000
) (
  input logic               CLK,
  input logic               RST_N,
  sw_debounce_led_if.slave  sw_if
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_chk
    $error("sw_debounce_led: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {REL, PRESS_CHK, HELD, REL_CHK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            s1_q, s1_d, s2_q, s2_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            led_q, led_d;
  logic            stable_q, stable_d;
  logic            long_q, long_d;

`ifdef SW_LONG_PRESS_EN
  localparam int LCW = $clog2(LONG_CYCLES + 1);
  localparam logic [LCW-1:0] LCNT_TERM = LCW'(LONG_CYCLES - 1);
  localparam logic [LCW-1:0] LCNT_SAT  = LCW'(LONG_CYCLES);
  logic [LCW-1:0]  lcnt_q, lcnt_d;
`endif

  always_comb begin
    s1_d      = sw_if.SW0;
    s2_d      = s1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    led_d     = led_q;
    stable_d  = stable_q;
    long_d    = 1'b0;

    case (state_q)
      REL: begin
        if (s2_q) begin
          state_d = PRESS_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_CHK: begin
        if (!s2_q) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d  = HELD;
          cnt_d    = '0;
          press_d  = 1'b1;
          stable_d = 1'b1;
          led_d    = ~led_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s2_q) begin
          state_d = REL_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      REL_CHK: begin
        if (s2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d   = REL;
          cnt_d     = '0;
          release_d = 1'b1;
          stable_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = '0;
      end
    endcase

`ifdef SW_LONG_PRESS_EN
    // lcnt survives a REL_CHK bounce; parking at LCNT_SAT marks "already fired".
    lcnt_d = lcnt_q;
    if (state_q == HELD && s2_q) begin
      if (lcnt_q < LCNT_TERM) begin
        lcnt_d = lcnt_q + LCW'(1);
      end else if (lcnt_q == LCNT_TERM) begin
        lcnt_d = LCNT_SAT;
        long_d = 1'b1;
        led_d  = 1'b0;
      end
    end else if (state_q == REL || state_q == PRESS_CHK) begin
      lcnt_d = '0;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= REL;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      led_q     <= 1'b0;
      stable_q  <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      led_q     <= led_d;
      stable_q  <= stable_d;
      long_q    <= long_d;
    end
  end

`ifdef SW_LONG_PRESS_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lcnt_q <= '0;
    end else begin
      lcnt_q <= lcnt_d;
    end
  end
`endif

  assign sw_if.LED0       = led_q;
  assign sw_if.PRESS      = press_q;
  assign sw_if.RELEASE    = release_q;
  assign sw_if.SW_STABLE  = stable_q;
  assign sw_if.LONG_PRESS = long_q;

endmodule
